// File: rtl/mem_pkg.sv
// Shared memory-port definitions: width codes and arbiter owner states.
// Both the data-port arbiter and the memory controller use these.
package mem_pkg;

    localparam logic [1:0] MEM_W_WORD = 2'd0;
    localparam logic [1:0] MEM_W_BYTE = 2'd1;
    localparam logic [1:0] MEM_W_HALF = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Width code 3 decodes as a word access, the same as code 0.
    function automatic logic [1:0] norm_width(input logic [1:0] w);
        return (w == MEM_W_BYTE || w == MEM_W_HALF) ? w : MEM_W_WORD;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and controller signals of the shared data port.
// The arbiter uses the slave view; requesters and controller use the master view.
interface mem_port_arbiter_if;

    logic        i_m0_req,   i_m1_req;
    logic        i_m0_lock,  i_m1_lock;
    logic [31:0] i_m0_addr,  i_m1_addr;
    logic [31:0] i_m0_wdata, i_m1_wdata;
    logic [1:0]  i_m0_width, i_m1_width;
    logic        i_m0_we,    i_m1_we;
    logic        i_m0_zext,  i_m1_zext;
    logic        o_m0_gnt,   o_m1_gnt;
    logic        o_m0_rvalid, o_m1_rvalid;
    logic [31:0] o_m0_rdata, o_m1_rdata;

    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [1:0]  o_mem_width;
    logic        o_mem_we;
    logic        o_mem_zext;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_m0_req, i_m0_lock, i_m0_addr, i_m0_wdata, i_m0_width, i_m0_we, i_m0_zext,
        input  i_m1_req, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_width, i_m1_we, i_m1_zext,
        output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
        output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        output o_mem_addr, o_mem_wdata, o_mem_width, o_mem_we, o_mem_zext,
        input  i_mem_rdata
    );

    modport master (
        output i_m0_req, i_m0_lock, i_m0_addr, i_m0_wdata, i_m0_width, i_m0_we, i_m0_zext,
        output i_m1_req, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_width, i_m1_we, i_m1_zext,
        input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
        input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        input  o_mem_addr, o_mem_wdata, o_mem_width, o_mem_we, o_mem_zext,
        output i_mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the memory controller data port: round-robin with bounded
// locking, width-hold hazard bubbles, and routing of 1-cycle read data to its issuer.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    arb_state_t state, state_nxt;
    logic       rr, rr_nxt;
    logic [7:0] lock_cnt, lock_cnt_nxt;
    logic       rd_pend, rd_src;
    logic [1:0] held_width;
    logic       held_zext;

    logic [1:0]       req_v, lock_v, we_v, zext_v;
    logic [1:0][1:0]  width_v;
    logic [1:0][31:0] addr_v, wdata_v;

    assign req_v   = {bus.i_m1_req,   bus.i_m0_req};
    assign lock_v  = {bus.i_m1_lock,  bus.i_m0_lock};
    assign we_v    = {bus.i_m1_we,    bus.i_m0_we};
    assign zext_v  = {bus.i_m1_zext,  bus.i_m0_zext};
    assign width_v = {bus.i_m1_width, bus.i_m0_width};
    assign addr_v  = {bus.i_m1_addr,  bus.i_m0_addr};
    assign wdata_v = {bus.i_m1_wdata, bus.i_m0_wdata};

    logic cand, cand_valid, hazard_ok, grant, win;

    // Pick a candidate, then hold it off if it would disturb an in-flight read's width.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        cand       = 1'b0;
        cand_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_v == 2'b11) begin
                    cand_valid = 1'b1;
                    cand       = rr;
                end else if (req_v[0]) begin
                    cand_valid = 1'b1;
                    cand       = 1'b0;
                end else if (req_v[1]) begin
                    cand_valid = 1'b1;
                    cand       = 1'b1;
                end
            end
            OWN0: begin
                cand_valid = req_v[0];
                cand       = 1'b0;
            end
            OWN1: begin
                cand_valid = req_v[1];
                cand       = 1'b1;
            end
            default: ;
        endcase
        hazard_ok = !rd_pend
                    || (norm_width(width_v[cand]) == norm_width(held_width)
                        && zext_v[cand] == held_zext);
        grant = cand_valid && hazard_ok && i_rst_n;
        win   = cand;
    end

    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr;
        lock_cnt_nxt = lock_cnt;
        if (grant) begin
            rr_nxt = ~win;
            if (state == IDLE) begin
                if (lock_v[win]) begin
                    state_nxt    = win ? OWN1 : OWN0;
                    lock_cnt_nxt = 8'd1;
                end
            end else begin
                lock_cnt_nxt = lock_cnt + 8'd1;
                if (!lock_v[win] || lock_cnt_nxt >= LOCK_LIMIT) begin
                    state_nxt = IDLE;
                end
            end
        end
    end

    always_comb begin
        bus.o_m0_gnt    = grant && !win;
        bus.o_m1_gnt    = grant && win;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_width = held_width;
        bus.o_mem_zext  = held_zext;
        bus.o_mem_we    = 1'b0;
        if (grant) begin
            bus.o_mem_addr  = addr_v[win];
            bus.o_mem_wdata = wdata_v[win];
            bus.o_mem_width = width_v[win];
            bus.o_mem_zext  = zext_v[win];
            bus.o_mem_we    = we_v[win];
        end
        bus.o_m0_rvalid = rd_pend && !rd_src;
        bus.o_m1_rvalid = rd_pend && rd_src;
        bus.o_m0_rdata  = bus.o_m0_rvalid ? bus.i_mem_rdata : '0;
        bus.o_m1_rdata  = bus.o_m1_rvalid ? bus.i_mem_rdata : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            rr         <= 1'b0;
            lock_cnt   <= 8'd0;
            rd_pend    <= 1'b0;
            rd_src     <= 1'b0;
            held_width <= MEM_W_WORD;
            held_zext  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            rr       <= rr_nxt;
            lock_cnt <= lock_cnt_nxt;
            rd_pend  <= grant && !we_v[win];
            if (grant) begin
                rd_src     <= win;
                held_width <= width_v[win];
                held_zext  <= zext_v[win];
            end
        end
    end

endmodule
